// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALUOp/funct encodings, ALU operation codes, hilo selects and mult/div FSM states.
package alu_ctrl_pkg;
  localparam logic [3:0] ALUOP_ADDI = 4'b0000, ALUOP_LW = 4'b0001, ALUOP_SW = 4'b0010, ALUOP_ORI = 4'b0011;
  localparam logic [3:0] ALUOP_ANDI = 4'b0100, ALUOP_LUI = 4'b0101, ALUOP_BEQ = 4'b0110, ALUOP_BNE = 4'b0111;
  localparam logic [3:0] ALUOP_RTYPE = 4'b1111;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_MFHI = 6'h10, F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_NOR = 6'h27, F_SLT = 6'h2A;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_NOR = 4'b0010, OP_ADD = 4'b0011, OP_SUB = 4'b0100;
  localparam logic [3:0] OP_LUI = 4'b0101, OP_SLL = 4'b0110, OP_SRL = 4'b0111, OP_SLT = 4'b1000, OP_NOP = 4'b1001;
  localparam logic [1:0] HL_ALU = 2'b00, HL_HI = 2'b01, HL_LO = 2'b10;
  typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_e;
endpackage

// File: rtl/md_iter_unit.sv
// md_iter_unit: iterative shift-add multiplier / restoring divider on operand magnitudes, with sign fixup and HI/LO.
module md_iter_unit
  import alu_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic         is_div_i,
  input  logic         is_signed_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);
  localparam int CW = $clog2(W);
  md_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] r_q, r_d, q_q, q_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic div_q, div_d, negq_q, negq_d, nega_q, nega_d, done_q, done_d;
  logic sa, sb;
  logic [W-1:0] abs_a, abs_b;
  logic [W:0] msum, shl, diff;
  logic [2*W-1:0] prod;
  assign sa = is_signed_i & a_i[W-1];
  assign sb = is_signed_i & b_i[W-1];
  assign abs_a = sa ? -a_i : a_i;
  assign abs_b = sb ? -b_i : b_i;
  assign msum = {1'b0, r_q} + {1'b0, q_q[0] ? b_q : '0};
  assign shl = {r_q, q_q[W-1]};
  assign diff = shl - {1'b0, b_q};
  assign prod = negq_q ? -{r_q, q_q} : {r_q, q_q};
  // r_q is the product high half or partial remainder; q_q is the multiplier or quotient shift register
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    r_d = r_q;
    q_d = q_q;
    b_d = b_q;
    div_d = div_q;
    negq_d = negq_q;
    nega_d = nega_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    if (state_q == IDLE && start_i) begin
      state_d = RUN;
      cnt_d = '0;
      r_d = '0;
      q_d = abs_a;
      b_d = abs_b;
      div_d = is_div_i;
      negq_d = sa ^ sb;
      nega_d = sa;
    end else if (state_q == RUN) begin
      state_d = (cnt_q == CW'(W - 1)) ? FIX : RUN;
      cnt_d = cnt_q + CW'(1);
      r_d = div_q ? (diff[W] ? shl[W-1:0] : diff[W-1:0]) : msum[W:1];
      q_d = div_q ? {q_q[W-2:0], ~diff[W]} : {msum[0], q_q[W-1:1]};
    end else if (state_q == FIX) begin
      state_d = IDLE;
      done_d = 1'b1;
      hi_d = div_q ? (nega_q ? -r_q : r_q) : prod[2*W-1:W];
      lo_d = div_q ? ((b_q == '0) ? '1 : (negq_q ? -q_q : q_q)) : prod[W-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      r_q <= '0;
      q_q <= '0;
      b_q <= '0;
      div_q <= 1'b0;
      negq_q <= 1'b0;
      nega_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      r_q <= r_d;
      q_q <= q_d;
      b_q <= b_d;
      div_q <= div_d;
      negq_q <= negq_d;
      nega_q <= nega_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
    end
  end
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign hi_o = hi_q;
  assign lo_o = lo_q;
endmodule

// File: rtl/alu_control_md.sv
// alu_control_md: ALU control decode plus mult/div unit with HI/LO and stall handshake.
module alu_control_md
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ALUOP_WIDTH = 4,
  parameter int FUNCT_WIDTH = 6,
  parameter int OPER_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_i,
  input  logic [ALUOP_WIDTH-1:0] alu_op_i,
  input  logic [FUNCT_WIDTH-1:0] funct_i,
  input  logic [DATA_WIDTH-1:0]  rs_data_i,
  input  logic [DATA_WIDTH-1:0]  rt_data_i,
  output logic [OPER_WIDTH-1:0]  alu_operation_o,
  output logic                   jr_o,
  output logic [1:0]             hilo_sel_o,
  output logic                   stall_o,
  output logic                   md_busy_o,
  output logic                   md_done_o,
  output logic [DATA_WIDTH-1:0]  hi_o,
  output logic [DATA_WIDTH-1:0]  lo_o
);
  logic rtype, is_md, is_mf, busy;
  logic [3:0] op;
  assign rtype = alu_op_i == ALUOP_RTYPE;
  assign is_md = rtype & (funct_i == F_MULT | funct_i == F_MULTU | funct_i == F_DIV | funct_i == F_DIVU);
  assign is_mf = rtype & (funct_i == F_MFHI | funct_i == F_MFLO);
  always_comb begin
    op = OP_NOP;
    if (rtype) begin
      case (funct_i)
        F_AND:   op = OP_AND;
        F_OR:    op = OP_OR;
        F_NOR:   op = OP_NOR;
        F_ADD:   op = OP_ADD;
        F_SUB:   op = OP_SUB;
        F_SLL:   op = OP_SLL;
        F_SRL:   op = OP_SRL;
        F_SLT:   op = OP_SLT;
        default: op = OP_NOP;
      endcase
    end else begin
      case (alu_op_i)
        ALUOP_ADDI, ALUOP_LW, ALUOP_SW: op = OP_ADD;
        ALUOP_ORI:                      op = OP_OR;
        ALUOP_ANDI:                     op = OP_AND;
        ALUOP_LUI:                      op = OP_LUI;
        ALUOP_BEQ, ALUOP_BNE:           op = OP_SUB;
        default:                        op = OP_NOP;
      endcase
    end
  end
  assign alu_operation_o = OPER_WIDTH'(op);
  assign jr_o = rtype & (funct_i == F_JR);
  assign hilo_sel_o = !rtype ? HL_ALU : (funct_i == F_MFHI) ? HL_HI : (funct_i == F_MFLO) ? HL_LO : HL_ALU;
  assign stall_o = valid_i & busy & (is_md | is_mf);
  assign md_busy_o = busy;
  // funct bit 1 separates DIV* from MULT*, bit 0 marks the unsigned variants
  md_iter_unit #(.W(DATA_WIDTH)) u_md (
    .clk        (clk),
    .reset      (reset),
    .start_i    (valid_i & is_md & ~busy),
    .is_div_i   (funct_i[1]),
    .is_signed_i(~funct_i[0]),
    .a_i        (rs_data_i),
    .b_i        (rt_data_i),
    .busy_o     (busy),
    .done_o     (md_done_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );
endmodule

// File: tb/tb_alu_control_md.sv
// tb_alu_control_md: table-driven decode checks plus directed mult/div, stall and reset sequences.
module tb_alu_control_md;
  logic clk = 1'b0;
  logic reset, valid, jr, stall, busy, done;
  logic [3:0] aop, op;
  logic [5:0] funct;
  logic [1:0] hs;
  logic [31:0] rs, rt, hi, lo;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  alu_control_md dut (
    .clk(clk), .reset(reset), .valid_i(valid), .alu_op_i(aop), .funct_i(funct),
    .rs_data_i(rs), .rt_data_i(rt), .alu_operation_o(op), .jr_o(jr), .hilo_sel_o(hs),
    .stall_o(stall), .md_busy_o(busy), .md_done_o(done), .hi_o(hi), .lo_o(lo)
  );
  typedef struct {
    logic [3:0] a;
    logic [5:0] f;
    logic [3:0] op;
    logic jr;
    logic [1:0] hs;
  } dec_t;
  dec_t tv[$];
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run_md(string nm, logic [5:0] f, logic [31:0] a, logic [31:0] b, logic [31:0] eh, logic [31:0] el);
    int cyc;
    @(negedge clk);
    valid = 1'b1; aop = 4'hF; funct = f; rs = a; rt = b;
    chk({nm, "_idle"}, 64'(busy), 64'(0));
    @(posedge clk);
    #1 valid = 1'b0; rs = $urandom; rt = $urandom;
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk({nm, "_busy_cycles"}, 64'(cyc), 64'(33));
    chk({nm, "_done"}, 64'(done), 64'(1));
    chk({nm, "_hi"}, 64'(hi), 64'(eh));
    chk({nm, "_lo"}, 64'(lo), 64'(el));
    @(negedge clk);
    chk({nm, "_done_pulse"}, 64'(done), 64'(0));
  endtask
  initial begin
    int cyc, st, add_st, dones;
    reset = 1'b1; valid = 1'b0; aop = 4'h0; funct = 6'h0; rs = '0; rt = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hilo", {hi, lo}, 64'(0));
    tv.push_back('{4'h0, 6'h00, 4'b0011, 1'b0, 2'b00});
    tv.push_back('{4'h1, 6'h3F, 4'b0011, 1'b0, 2'b00});
    tv.push_back('{4'h2, 6'h24, 4'b0011, 1'b0, 2'b00});
    tv.push_back('{4'h3, 6'h00, 4'b0001, 1'b0, 2'b00});
    tv.push_back('{4'h4, 6'h08, 4'b0000, 1'b0, 2'b00});
    tv.push_back('{4'h5, 6'h10, 4'b0101, 1'b0, 2'b00});
    tv.push_back('{4'h6, 6'h00, 4'b0100, 1'b0, 2'b00});
    tv.push_back('{4'h7, 6'h00, 4'b0100, 1'b0, 2'b00});
    tv.push_back('{4'hA, 6'h20, 4'b1001, 1'b0, 2'b00});
    tv.push_back('{4'hF, 6'h24, 4'b0000, 1'b0, 2'b00});
    tv.push_back('{4'hF, 6'h25, 4'b0001, 1'b0, 2'b00});
    tv.push_back('{4'hF, 6'h27, 4'b0010, 1'b0, 2'b00});
    tv.push_back('{4'hF, 6'h20, 4'b0011, 1'b0, 2'b00});
    tv.push_back('{4'hF, 6'h22, 4'b0100, 1'b0, 2'b00});
    tv.push_back('{4'hF, 6'h00, 4'b0110, 1'b0, 2'b00});
    tv.push_back('{4'hF, 6'h02, 4'b0111, 1'b0, 2'b00});
    tv.push_back('{4'hF, 6'h2A, 4'b1000, 1'b0, 2'b00});
    tv.push_back('{4'hF, 6'h08, 4'b1001, 1'b1, 2'b00});
    tv.push_back('{4'hF, 6'h10, 4'b1001, 1'b0, 2'b01});
    tv.push_back('{4'hF, 6'h12, 4'b1001, 1'b0, 2'b10});
    tv.push_back('{4'hF, 6'h18, 4'b1001, 1'b0, 2'b00});
    tv.push_back('{4'hF, 6'h1B, 4'b1001, 1'b0, 2'b00});
    tv.push_back('{4'hF, 6'h3F, 4'b1001, 1'b0, 2'b00});
    foreach (tv[i]) begin
      @(posedge clk);
      #1 aop = tv[i].a; funct = tv[i].f;
      @(negedge clk);
      chk($sformatf("dec%0d_%h_%h", i, tv[i].a, tv[i].f), 64'({jr, hs, op}), 64'({tv[i].jr, tv[i].hs, tv[i].op}));
    end
    // bubble carrying a mult funct must neither start nor stall
    @(negedge clk);
    valid = 1'b0; aop = 4'hF; funct = 6'h18; rs = 32'd3; rt = 32'd3;
    repeat (2) @(negedge clk);
    chk("bubble_busy", 64'({busy, stall}), 64'(0));
    run_md("mult", 6'h18, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md("divu", 6'h1B, 32'd100, 32'd7, 32'h2, 32'hE);
    run_md("div", 6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("divu0", 6'h1B, 32'd5, 32'd0, 32'h5, 32'hFFFFFFFF);
    run_md("div_ovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_md("multu", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    // MFLO held through a DIVU, with one ADD slipped in mid-run
    @(negedge clk);
    valid = 1'b1; aop = 4'hF; funct = 6'h1B; rs = 32'd100; rt = 32'd7;
    @(posedge clk);
    #1 funct = 6'h12;
    cyc = 0; st = 0; add_st = 1;
    @(negedge clk);
    while (busy && cyc < 100) begin
      cyc++;
      if (funct == 6'h12) st += int'(stall);
      else add_st = int'(stall);
      @(posedge clk);
      #1 funct = (cyc == 10) ? 6'h20 : 6'h12;
      @(negedge clk);
    end
    chk("mflo_stall_cycles", 64'(st), 64'(32));
    chk("add_no_stall", 64'(add_st), 64'(0));
    chk("mflo_done_stall", 64'({done, stall}), 64'(2'b10));
    chk("mflo_sel", 64'(hs), 64'(2'b10));
    chk("mflo_lo", 64'(lo), 64'(32'hE));
    // reset in the middle of RUN aborts with no done pulse
    @(negedge clk);
    valid = 1'b1; funct = 6'h18; rs = 32'd9; rt = 32'd9;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'({busy, done}), 64'(0));
    chk("abort_hilo", {hi, lo}, 64'(0));
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      dones += int'(done);
    end
    chk("abort_no_done", 64'(dones), 64'(0));
    run_md("mult_after_rst", 6'h18, 32'd2, 32'd3, 32'h0, 32'h6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
